// File: rtl/alu_arbiter_pkg.sv
// Shared ALU opcodes, arbiter sizing constants and a saturating-increment helper.
// Imported by the arbiter top and by the ALU, so both agree on the opcode encoding.
// Compile this file first.
package alu_arbiter_pkg;

    // Datapath width the ALU is built for. The arbiter's W parameter must match it.
    localparam int ALU_W          = 32;
    // Number of requesters sharing the ALU.
    localparam int ALU_ARB_NREQ   = 2;
    // Width of the optional statistics counters.
    localparam int ALU_ARB_STAT_W = 16;

    // ALU opcode encoding. Values 8..15 are undefined and produce a zero result.
    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SUB = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SRA = 4'd7
    } alu_op_e;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [ALU_ARB_STAT_W-1:0] sat_inc(input logic [ALU_ARB_STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU: C = op(A, B) plus zero and sign flags; zero latency.
// No flow control; the caller registers the result.
// Ports: op_i (4b opcode), a_i/b_i (W operands, shifts use b_i[4:0]),
//        c_o (W result), zero_o (C == 0), sgn_o (C[W-1]).
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [3:0]   op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] c_o,
    output logic         zero_o,
    output logic         sgn_o
);

    logic [4:0]   shamt;
    logic [W-1:0] c;

    assign shamt = b_i[4:0];

    always_comb begin
        c = '0;
        case (op_i)
            ALU_AND: c = a_i & b_i;
            ALU_OR:  c = a_i | b_i;
            ALU_ADD: c = a_i + b_i;
            ALU_SUB: c = a_i - b_i;
            ALU_XOR: c = a_i ^ b_i;
            ALU_SLL: c = a_i << shamt;
            ALU_SRL: c = a_i >> shamt;
            ALU_SRA: c = $unsigned($signed(a_i) >>> shamt);
            // Undefined opcodes fall through to a zero result (zero=1, sgn=0).
            default: c = '0;
        endcase
    end

    assign c_o    = c;
    assign zero_o = (c == '0);
    assign sgn_o  = c[W-1];

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between two valid/ready requesters, one registered
// response slot each; latency 1 cycle accept->response, 1 op/cycle total.
// Backpressure: a requester whose slot is full and not draining gets in_ready=0.
//
// Ports: clk, rst_n (async active-low); in_valid/in_ready[1:0]; in_op0/1, in_a0/1,
//        in_b0/1 request fields; rsp_valid[1:0]/rsp_ready[1:0]; rsp_data0/1,
//        rsp_zero0/1, rsp_sgn0/1 registered results.
// Optional: define ALU_ARB_STATS_EN to add saturating 16-bit counters stat_grant0/1
//           (grants completed) and stat_stall0/1 (cycles with in_valid & ~in_ready).
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int W          = 32,   // must equal ALU_W
    parameter int FIRST_PRIO = 0     // winner of the first contested cycle after reset
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                in_valid,
    output logic [1:0]                in_ready,
    input  logic [3:0]                in_op0,
    input  logic [W-1:0]              in_a0,
    input  logic [W-1:0]              in_b0,
    input  logic [3:0]                in_op1,
    input  logic [W-1:0]              in_a1,
    input  logic [W-1:0]              in_b1,
    output logic [1:0]                rsp_valid,
    input  logic [1:0]                rsp_ready,
    output logic [W-1:0]              rsp_data0,
    output logic                      rsp_zero0,
    output logic                      rsp_sgn0,
    output logic [W-1:0]              rsp_data1,
    output logic                      rsp_zero1,
    output logic                      rsp_sgn1
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [ALU_ARB_STAT_W-1:0] stat_grant0,
    output logic [ALU_ARB_STAT_W-1:0] stat_grant1,
    output logic [ALU_ARB_STAT_W-1:0] stat_stall0,
    output logic [ALU_ARB_STAT_W-1:0] stat_stall1
`endif
);

    // Pointer value after reset: "last granted" is the requester that should lose
    // the first contested cycle, i.e. the one that is not FIRST_PRIO.
    localparam logic LAST_RST = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;

    logic [1:0]   elig;
    logic [1:0]   grant;
    logic         last_q, last_d;

    logic [1:0]   rsp_vld_q, rsp_vld_d;
    logic [W-1:0] data0_q, data0_d, data1_q, data1_d;
    logic         zero0_q, zero0_d, zero1_q, zero1_d;
    logic         sgn0_q, sgn0_d, sgn1_q, sgn1_d;

    logic [3:0]   alu_op;
    logic [W-1:0] alu_a, alu_b, alu_c;
    logic         alu_zero, alu_sgn;

    // A requester may be served when its slot is empty or being emptied this cycle.
    assign elig = in_valid & (~rsp_vld_q | rsp_ready);

    always_comb begin
        grant = 2'b00;
        case (elig)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // Contention: serve whoever did not win last time.
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Pointer only moves on an actual grant; idle cycles keep the history.
    always_comb begin
        last_d = last_q;
        if (grant[1]) begin
            last_d = 1'b1;
        end else if (grant[0]) begin
            last_d = 1'b0;
        end
    end

    // rst_n gate keeps in_ready low for the whole reset window, even though the
    // cleared slots would otherwise make valid requesters eligible.
    assign in_ready = grant & {2{rst_n}};

    // Idle ALU input is ADD 0+0 so the operand bus stays quiet with no grant.
    always_comb begin
        alu_op = ALU_ADD;
        alu_a  = '0;
        alu_b  = '0;
        if (grant[0]) begin
            alu_op = in_op0;
            alu_a  = in_a0;
            alu_b  = in_b0;
        end else if (grant[1]) begin
            alu_op = in_op1;
            alu_a  = in_a1;
            alu_b  = in_b1;
        end
    end

    alu_arbiter_alu #(
        .W (W)
    ) u_alu (
        .op_i   (alu_op),
        .a_i    (alu_a),
        .b_i    (alu_b),
        .c_o    (alu_c),
        .zero_o (alu_zero),
        .sgn_o  (alu_sgn)
    );

    // Slot update: a drain clears valid, a grant (re)loads and sets it. Doing the
    // grant last lets a drain+grant in one cycle keep valid high (1 op/cycle).
    // Data is held across a drain; only a new grant overwrites it.
    always_comb begin
        rsp_vld_d = (rsp_vld_q & ~rsp_ready) | grant;
        data0_d   = data0_q;
        zero0_d   = zero0_q;
        sgn0_d    = sgn0_q;
        data1_d   = data1_q;
        zero1_d   = zero1_q;
        sgn1_d    = sgn1_q;
        if (grant[0]) begin
            data0_d = alu_c;
            zero0_d = alu_zero;
            sgn0_d  = alu_sgn;
        end
        if (grant[1]) begin
            data1_d = alu_c;
            zero1_d = alu_zero;
            sgn1_d  = alu_sgn;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q    <= LAST_RST;
            rsp_vld_q <= 2'b00;
            data0_q   <= '0;
            zero0_q   <= 1'b0;
            sgn0_q    <= 1'b0;
            data1_q   <= '0;
            zero1_q   <= 1'b0;
            sgn1_q    <= 1'b0;
        end else begin
            last_q    <= last_d;
            rsp_vld_q <= rsp_vld_d;
            data0_q   <= data0_d;
            zero0_q   <= zero0_d;
            sgn0_q    <= sgn0_d;
            data1_q   <= data1_d;
            zero1_q   <= zero1_d;
            sgn1_q    <= sgn1_d;
        end
    end

    assign rsp_valid = rsp_vld_q;
    assign rsp_data0 = data0_q;
    assign rsp_zero0 = zero0_q;
    assign rsp_sgn0  = sgn0_q;
    assign rsp_data1 = data1_q;
    assign rsp_zero1 = zero1_q;
    assign rsp_sgn1  = sgn1_q;

`ifdef ALU_ARB_STATS_EN
    logic [ALU_ARB_STAT_W-1:0] gnt_cnt_q   [ALU_ARB_NREQ];
    logic [ALU_ARB_STAT_W-1:0] gnt_cnt_d   [ALU_ARB_NREQ];
    logic [ALU_ARB_STAT_W-1:0] stall_cnt_q [ALU_ARB_NREQ];
    logic [ALU_ARB_STAT_W-1:0] stall_cnt_d [ALU_ARB_NREQ];

    always_comb begin
        for (int i = 0; i < ALU_ARB_NREQ; i++) begin
            gnt_cnt_d[i]   = gnt_cnt_q[i];
            stall_cnt_d[i] = stall_cnt_q[i];
            if (grant[i]) begin
                gnt_cnt_d[i] = sat_inc(gnt_cnt_q[i]);
            end
            if (in_valid[i] && !in_ready[i]) begin
                stall_cnt_d[i] = sat_inc(stall_cnt_q[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ALU_ARB_NREQ; i++) begin
                gnt_cnt_q[i]   <= '0;
                stall_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ALU_ARB_NREQ; i++) begin
                gnt_cnt_q[i]   <= gnt_cnt_d[i];
                stall_cnt_q[i] <= stall_cnt_d[i];
            end
        end
    end

    assign stat_grant0 = gnt_cnt_q[0];
    assign stat_grant1 = gnt_cnt_q[1];
    assign stat_stall0 = stall_cnt_q[0];
    assign stat_stall1 = stall_cnt_q[1];
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized + directed bench for alu_arbiter against a transaction-level model.
// Inputs change on the falling edge; in_ready is sampled 1 time unit later and
// registered outputs are compared on the following falling edge.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  in_valid = 2'b00;
    logic [1:0]  in_ready;
    logic [3:0]  in_op0 = 4'd0, in_op1 = 4'd0;
    logic [31:0] in_a0 = '0, in_b0 = '0, in_a1 = '0, in_b1 = '0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = 2'b00;
    logic [31:0] rsp_data0, rsp_data1;
    logic        rsp_zero0, rsp_zero1, rsp_sgn0, rsp_sgn1;
`ifdef ALU_ARB_STATS_EN
    logic [15:0] stat_grant0, stat_grant1, stat_stall0, stat_stall1;
`endif

    always #5 clk = ~clk;

    alu_arbiter #(.W(32), .FIRST_PRIO(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op0    (in_op0),
        .in_a0     (in_a0),
        .in_b0     (in_b0),
        .in_op1    (in_op1),
        .in_a1     (in_a1),
        .in_b1     (in_b1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data0 (rsp_data0),
        .rsp_zero0 (rsp_zero0),
        .rsp_sgn0  (rsp_sgn0),
        .rsp_data1 (rsp_data1),
        .rsp_zero1 (rsp_zero1),
        .rsp_sgn1  (rsp_sgn1)
`ifdef ALU_ARB_STATS_EN
        ,
        .stat_grant0 (stat_grant0),
        .stat_grant1 (stat_grant1),
        .stat_stall0 (stat_stall0),
        .stat_stall1 (stat_stall1)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model (transaction level) ----------------
    bit          m_vld  [2];
    logic [31:0] m_dat  [2];
    bit          m_zero [2];
    bit          m_sgn  [2];
    int          m_last;          // requester index granted most recently
    int          m_gnt  [2];
    int          m_stall[2];

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            4'd0: return a & b;
            4'd1: return a | b;
            4'd2: return a + b;
            4'd3: return a - b;
            4'd4: return a ^ b;
            4'd5: return a << sh;
            4'd6: return a >> sh;
            4'd7: return $unsigned($signed(a) >>> sh);
            default: return 32'd0;
        endcase
    endfunction

    // Who the spec says must be served, given current requests and slot occupancy.
    function automatic logic [1:0] model_grant();
        bit e0, e1;
        e0 = in_valid[0] && (!m_vld[0] || rsp_ready[0]);
        e1 = in_valid[1] && (!m_vld[1] || rsp_ready[1]);
        if (e0 && e1) return (m_last == 0) ? 2'b10 : 2'b01;
        if (e0) return 2'b01;
        if (e1) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_vld[i] = 0; m_dat[i] = '0; m_zero[i] = 0; m_sgn[i] = 0;
            m_gnt[i] = 0; m_stall[i] = 0;
        end
        m_last = 1;   // so requester 0 (FIRST_PRIO) wins the first contest
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        check("rsp_valid", 32'(rsp_valid), 32'({m_vld[1], m_vld[0]}));
        check("rsp_data0", rsp_data0, m_dat[0]);
        check("rsp_zero0", 32'(rsp_zero0), 32'(m_zero[0]));
        check("rsp_sgn0",  32'(rsp_sgn0),  32'(m_sgn[0]));
        check("rsp_data1", rsp_data1, m_dat[1]);
        check("rsp_zero1", 32'(rsp_zero1), 32'(m_zero[1]));
        check("rsp_sgn1",  32'(rsp_sgn1),  32'(m_sgn[1]));
`ifdef ALU_ARB_STATS_EN
        check("stat_grant0", 32'(stat_grant0), 32'(m_gnt[0]));
        check("stat_grant1", 32'(stat_grant1), 32'(m_gnt[1]));
        check("stat_stall0", 32'(stat_stall0), 32'(m_stall[0]));
        check("stat_stall1", 32'(stat_stall1), 32'(m_stall[1]));
`endif
    endtask

    // Called on a falling edge after inputs are driven; returns at the next falling edge.
    task automatic step(output logic [1:0] g, output logic [1:0] ir);
        logic [3:0]  op [2];
        logic [31:0] a  [2];
        logic [31:0] b  [2];
        logic [31:0] r;
        #1;
        g  = model_grant();
        ir = in_ready;
        check("in_ready", 32'(ir), 32'(g));
        op[0] = in_op0; a[0] = in_a0; b[0] = in_b0;
        op[1] = in_op1; a[1] = in_a1; b[1] = in_b1;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (in_valid[i] && !g[i] && m_stall[i] < 65535) m_stall[i]++;
            if (g[i]) begin
                r = ref_alu(op[i], a[i], b[i]);
                m_vld[i] = 1; m_dat[i] = r; m_zero[i] = (r == 0); m_sgn[i] = r[31];
                if (m_gnt[i] < 65535) m_gnt[i]++;
                m_last = i;
            end else if (rsp_ready[i]) begin
                m_vld[i] = 0;
            end
        end
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        if (i == 0) begin in_op0 = op; in_a0 = a; in_b0 = b; end
        else        begin in_op1 = op; in_a1 = a; in_b1 = b; end
    endtask

    logic [1:0]  g, ir;
    bit          pv  [2];
    logic [3:0]  rop [2];
    logic [31:0] ra  [2];
    logic [31:0] rb  [2];

    initial begin
        model_reset();
        in_valid = 2'b11;
        repeat (2) @(negedge clk);
        // Reset state, with requests asserted to show in_ready is gated.
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data0", rsp_data0, 32'd0);
        check("rst_rsp_data1", rsp_data1, 32'd0);
        in_valid = 2'b00;
        rst_n = 1'b1;
        @(negedge clk);

        // Single op: ADD 5+7 on requester 0.
        set_req(0, ALU_ADD, 32'd5, 32'd7); in_valid = 2'b01; rsp_ready = 2'b01;
        step(g, ir);
        check("s2_ready", 32'(ir), 32'h1);
        check("s2_data0", rsp_data0, 32'd12);
        check("s2_zero0", 32'(rsp_zero0), 32'd0);
        check("s2_sgn0",  32'(rsp_sgn0),  32'd0);

        // Requester 1 alone: SUB 3-3 -> zero flag.
        set_req(1, ALU_SUB, 32'd3, 32'd3); in_valid = 2'b10; rsp_ready = 2'b11;
        step(g, ir);
        check("s3_sub_ready", 32'(ir), 32'h2);
        check("s3_sub_data1", rsp_data1, 32'd0);
        check("s3_sub_zero1", 32'(rsp_zero1), 32'd1);

        // Contention for 6 cycles: grants must alternate 0,1,0,1,0,1.
        for (int k = 0; k < 6; k++) begin
            set_req(0, ALU_ADD, 32'(k), 32'(k)); set_req(1, ALU_SUB, 32'd3, 32'd3);
            in_valid = 2'b11; rsp_ready = 2'b11;
            step(g, ir);
            check("s3_alt_ready", 32'(ir), (k % 2 == 0) ? 32'h1 : 32'h2);
        end

        // Backpressure: SLL 1 by 0x24 (shamt 4), then hold slot 0 full.
        set_req(0, ALU_SLL, 32'd1, 32'h24); set_req(1, ALU_ADD, 32'd2, 32'd3);
        in_valid = 2'b11; rsp_ready = 2'b10;
        step(g, ir);
        check("s4_ready", 32'(ir), 32'h1);
        check("s4_data0", rsp_data0, 32'd16);
        set_req(0, ALU_ADD, 32'd1, 32'd1);
        for (int k = 0; k < 4; k++) begin
            step(g, ir);
            check("s4_bp_ready", 32'(ir), 32'h2);
            check("s4_bp_data0", rsp_data0, 32'd16);
            check("s4_bp_valid0", 32'(rsp_valid[0]), 32'd1);
        end
        rsp_ready = 2'b11;
        step(g, ir);
        check("s4_release_ready", 32'(ir), 32'h1);
        check("s4_release_data0", rsp_data0, 32'd2);

        // Back-to-back on requester 0: SRA then XOR, accepted every cycle.
        set_req(0, ALU_SRA, 32'h8000_0000, 32'd31); in_valid = 2'b01; rsp_ready = 2'b01;
        step(g, ir);
        check("s5_sra_ready", 32'(ir), 32'h1);
        check("s5_sra_data0", rsp_data0, 32'hFFFF_FFFF);
        check("s5_sra_sgn0",  32'(rsp_sgn0), 32'd1);
        set_req(0, ALU_XOR, 32'hF0F0_0000, 32'h0FF0_0000);
        step(g, ir);
        check("s5_xor_ready", 32'(ir), 32'h1);
        check("s5_xor_data0", rsp_data0, 32'hFF00_0000);
        check("s5_xor_valid0", 32'(rsp_valid[0]), 32'd1);

        // Undefined opcode.
        set_req(0, 4'hF, 32'd5, 32'd5);
        step(g, ir);
        check("s6_undef_data0", rsp_data0, 32'd0);
        check("s6_undef_zero0", 32'(rsp_zero0), 32'd1);
        check("s6_undef_sgn0",  32'(rsp_sgn0),  32'd0);

        // Fill both slots, then reset mid-transfer.
        in_valid = 2'b00; rsp_ready = 2'b11; step(g, ir);
        set_req(0, ALU_ADD, 32'd9, 32'd1); in_valid = 2'b01; rsp_ready = 2'b00; step(g, ir);
        set_req(1, ALU_OR,  32'd6, 32'd1); in_valid = 2'b10; step(g, ir);
        check("pre_rst_valid", 32'(rsp_valid), 32'h3);
        in_valid = 2'b11; rsp_ready = 2'b11;
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(rsp_valid), 32'd0);
        check("async_rst_ready", 32'(in_ready),  32'd0);
        check("async_rst_data0", rsp_data0, 32'd0);
        check("async_rst_data1", rsp_data1, 32'd0);
        check("async_rst_flags", 32'({rsp_zero0, rsp_sgn0, rsp_zero1, rsp_sgn1}), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1; rsp_ready = 2'b00;
        step(g, ir);
        check("post_rst_first_prio", 32'(ir), 32'h1);

        // Randomized traffic; requesters hold fields while waiting.
        ir = 2'b00;
        for (int i = 0; i < 2; i++) pv[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!(pv[i] && !ir[i])) begin
                    pv[i]  = ($urandom_range(0, 9) < 7);
                    rop[i] = 4'($urandom_range(0, 9));
                    case ($urandom_range(0, 3))
                        0:       ra[i] = 32'h0;
                        1:       ra[i] = 32'h8000_0000 | $urandom;
                        default: ra[i] = $urandom;
                    endcase
                    rb[i] = ($urandom_range(0, 1) == 1) ? ra[i] : $urandom;
                end
            end
            in_valid  = {pv[1], pv[0]};
            rsp_ready = 2'($urandom_range(0, 3));
            set_req(0, rop[0], ra[0], rb[0]);
            set_req(1, rop[1], ra[1], rb[1]);
            step(g, ir);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
